prog_iram: RTL and testbench
============================

PROG_IRAM -- requirements
Module: prog_iram

Interface
REQ-001 SHALL provide parameter DATA_W, default 16: instruction word width in bits; multiple of 8 and at least 8; BPW = DATA_W/8 bytes per word.
REQ-002 SHALL provide parameter AW, default 8: byte-address width; DEPTH = 2^(AW-1) words.
REQ-003 SHALL have port CLK  input  1  rising-edge clock.
REQ-004 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ADDR  input  AW  byte address for fetch; word index = ADDR[AW-1:1]; ADDR[0] ignored.
REQ-006 SHALL have port Q  output  DATA_W  fetched instruction word.
REQ-007 SHALL have port LD_START  input  1  request to begin a program load.
REQ-008 SHALL have port LD_VALID  input  1  loader byte valid.
REQ-009 SHALL have port LD_DATA  input  8  loader byte.
REQ-010 SHALL have port LD_LAST  input  1  marks the final byte of the program.
REQ-011 SHALL have port LD_READY  output  1  block accepts a loader byte.
REQ-012 SHALL have port BUSY  output  1  clear or load in progress.
REQ-013 SHALL have port RDY  output  1  memory contents valid for fetch.
REQ-014 SHALL have port ERR  output  1  sticky overflow flag for the last load.

Function
REQ-015 SHALL implement states CLEAR, IDLE and LOAD; BUSY = (state != IDLE); RDY = (state == IDLE); LD_READY = (state == LOAD).
REQ-016 CLEAR SHALL write zero to one word per cycle, sweeping index 0 to DEPTH-1 after RESET deasserts, then SHALL go to IDLE; no other writes occur in CLEAR.
REQ-017 An IDLE cycle with LD_START=1 SHALL enter LOAD on the next edge, zero the word pointer, zero the byte index and clear ERR.
REQ-018 LD_START SHALL be ignored in CLEAR and LOAD.
REQ-019 A byte SHALL be accepted on an edge with LD_VALID & LD_READY; byte k of a word fills bits [8k+7:8k] (little-endian).
REQ-020 On acceptance of byte BPW-1, or of any byte with LD_LAST=1, the assembled word SHALL be written at the pointer on that same edge; unfilled bytes are zero; the pointer then increments.
REQ-021 Acceptance with LD_LAST=1 SHALL return to IDLE on the same edge, so RDY=1 on the following cycle.
REQ-022 If word DEPTH-1 is written without LD_LAST, the block SHALL set ERR, return to IDLE and accept no further bytes; the pointer does not wrap.
REQ-023 Q SHALL equal mem[ADDR[AW-1:1]] when RDY=1 and SHALL be all-zero when RDY=0.
REQ-024 A word write and a fetch of the same index in the same cycle are not possible, because RDY=0 during writes.

Reset
REQ-025 RESET=1 SHALL force state CLEAR with clear index 0 and pointer 0, and SHALL drive ERR=0, BUSY=1, RDY=0, LD_READY=0 and Q=0.
REQ-026 RESET during LOAD SHALL discard any partially assembled word; the subsequent CLEAR zeroes all DEPTH words.
REQ-027 RDY SHALL first rise DEPTH cycles after the first cycle with RESET=0.

Configuration
REQ-028 With macro IRAM_REGQ_EN defined, Q SHALL be registered: Q after an edge = the REQ-023 value sampled at that edge, giving one-cycle fetch latency, and Q SHALL reset to 0.
REQ-029 Without IRAM_REGQ_EN, Q SHALL be combinational from ADDR, RDY and memory, with zero latency.

Verification (DATA_W=16, AW=8, DEPTH=128)
REQ-030 RESET=1 for 2 cycles, then 0 -> BUSY=1 and RDY=0 for 128 cycles, then RDY=1; Q=0x0000 for ADDR 0x00..0xFE.
REQ-031 LD_START, then bytes 0x91,0xF4,0xC9,0xF1 with LD_LAST on 0xF1 -> ADDR=0x00 gives Q=0xF491, ADDR=0x03 gives Q=0xF1C9; RDY=1 the cycle after the last accept.
REQ-032 Load bytes 0x01,0x00,0xAB with LD_LAST on 0xAB -> word 1 = 0x00AB, word 0 = 0x0001, ERR=0.
REQ-033 Load 256 bytes without LD_LAST -> LD_READY=0 after byte 256, ERR=1, RDY=1, byte 257 not accepted; the next LD_START clears ERR.
REQ-034 RESET=1 after 3 bytes of a load -> after the clear, all words read 0x0000 and ERR=0.
REQ-035 With IRAM_REGQ_EN, after a load, change ADDR 0x00->0x02 -> Q changes from word 0 to word 1 one edge later; without the macro, Q changes in the same cycle.

Source files
------------

// File: rtl/prog_iram_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_iram_if
// Description : Fetch and byte-loader bus of the program instruction RAM.
//               slave  - the RAM itself (drives Q and the status flags)
//               master - the CPU fetch port / program loader
//   ADDR     byte address for fetch (bit 0 ignored by the RAM)
//   Q        fetched instruction word
//   LD_START request to begin a program load
//   LD_VALID loader byte valid      LD_DATA loader byte
//   LD_LAST  final byte of program  LD_READY RAM accepts a loader byte
//   BUSY     clear or load running  RDY      contents valid for fetch
//   ERR      sticky overflow flag of the last load
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_iram_if #(
  parameter int DATA_W = 16,
  parameter int AW     = 8
);
  logic [AW-1:0]     ADDR;
  logic [DATA_W-1:0] Q;
  logic              LD_START;
  logic              LD_VALID;
  logic [7:0]        LD_DATA;
  logic              LD_LAST;
  logic              LD_READY;
  logic              BUSY;
  logic              RDY;
  logic              ERR;

  modport master (
    output ADDR, LD_START, LD_VALID, LD_DATA, LD_LAST,
    input  Q, LD_READY, BUSY, RDY, ERR
  );

  modport slave (
    input  ADDR, LD_START, LD_VALID, LD_DATA, LD_LAST,
    output Q, LD_READY, BUSY, RDY, ERR
  );
endinterface
`default_nettype wire

// File: rtl/prog_iram.sv
`default_nettype none
// ============================================================================
// Module      : prog_iram
// Description : Program instruction RAM with a byte-serial loader.
//               After reset the whole array is swept to zero (one word per
//               cycle), then fetches are served.  A load assembles bytes
//               little-endian into words and writes them sequentially from
//               word 0; running past the last word sets ERR.
// Ports       : CLK    rising-edge clock
//               RESET  synchronous, active-high reset
//               bus    prog_iram_if.slave (fetch + loader + status)
// Parameters  : DATA_W word width (multiple of 8, >= 8)
//               AW     byte-address width, DEPTH = 2^(AW-1) words
// Options     : IRAM_REGQ_EN - when defined, Q is registered (one-cycle
//               fetch latency); otherwise Q is combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_iram #(
  parameter int DATA_W = 16,
  parameter int AW     = 8
) (
  input  wire logic    CLK,
  input  wire logic    RESET,
  prog_iram_if.slave   bus
);

  localparam int c_BPW   = DATA_W / 8;
  localparam int c_DEPTH = 1 << (AW - 1);
  localparam int c_IW    = AW - 1;
  localparam int c_BIW   = (c_BPW > 1) ? $clog2(c_BPW) : 1;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [DATA_W-1:0]   r_mem [c_DEPTH];
  logic [c_IW-1:0]     r_clr_idx;
  logic [c_IW-1:0]     r_ptr;
  logic [c_BIW-1:0]    r_byte_idx;
  logic [DATA_W-1:0]   r_asm;
  logic                r_err;

  logic                w_accept;
  logic                w_word_done;
  logic                w_ovf;
  logic                w_clr_done;
  logic [DATA_W-1:0]   w_word;
  logic                w_we;
  logic [c_IW-1:0]     w_widx;
  logic [DATA_W-1:0]   w_wdata;
  logic [c_IW-1:0]     w_ridx;
  logic [DATA_W-1:0]   w_q;
  logic                w_unused_addr0;

  // --------------------------------------------------------------------------
  // Loader handshake decode
  // --------------------------------------------------------------------------
  assign w_accept    = bus.LD_VALID & (r_state == S_LOAD);
  assign w_word_done = w_accept & (bus.LD_LAST | (r_byte_idx == c_BIW'(c_BPW - 1)));
  // Filling the last word without LD_LAST means the program does not fit.
  assign w_ovf       = w_word_done & ~bus.LD_LAST & (r_ptr == c_IW'(c_DEPTH - 1));
  assign w_clr_done  = (r_state == S_CLEAR) & (r_clr_idx == c_IW'(c_DEPTH - 1));

  // Current partial word with the incoming byte merged into its lane.
  always_comb begin
    w_word = r_asm;
    for (int k = 0; k < c_BPW; k++) begin
      if (r_byte_idx == c_BIW'(k)) begin
        w_word[8*k +: 8] = bus.LD_DATA;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: begin
        if (w_clr_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        if (bus.LD_START) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if ((w_accept & bus.LD_LAST) | w_ovf) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // --------------------------------------------------------------------------
  // Clear sweep, load pointer, byte assembly, error flag
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_clr_idx  <= '0;
      r_ptr      <= '0;
      r_byte_idx <= '0;
      r_asm      <= '0;
      r_err      <= 1'b0;
    end else begin
      if (r_state == S_CLEAR) begin
        r_clr_idx <= r_clr_idx + 1'b1;
      end

      if ((r_state == S_IDLE) && bus.LD_START) begin
        r_ptr      <= '0;
        r_byte_idx <= '0;
        r_asm      <= '0;
        r_err      <= 1'b0;
      end

      if (w_accept) begin
        if (w_word_done) begin
          // Start the next word from zero so a short final word is padded.
          r_asm      <= '0;
          r_byte_idx <= '0;
          if (!w_ovf) begin
            r_ptr <= r_ptr + 1'b1;
          end
        end else begin
          r_asm      <= w_word;
          r_byte_idx <= r_byte_idx + 1'b1;
        end
      end

      if (w_ovf) begin
        r_err <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Memory write port: clear sweep or completed loader word.  Gated by RESET
  // so a word completing on a reset edge is discarded.
  // --------------------------------------------------------------------------
  assign w_we    = ~RESET & ((r_state == S_CLEAR) | w_word_done);
  assign w_widx  = (r_state == S_CLEAR) ? r_clr_idx : r_ptr;
  assign w_wdata = (r_state == S_CLEAR) ? '0 : w_word;

  always_ff @(posedge CLK) begin
    if (w_we) begin
      r_mem[w_widx] <= w_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Fetch port: word-addressed, forced to zero while not ready.
  // --------------------------------------------------------------------------
  assign w_ridx         = bus.ADDR[AW-1:1];
  assign w_unused_addr0 = bus.ADDR[0];
  assign w_q            = (r_state == S_IDLE) ? r_mem[w_ridx] : '0;

`ifdef IRAM_REGQ_EN
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_q <= '0;
    end else begin
      r_q <= w_q;
    end
  end

  assign bus.Q = r_q;
`else
  assign bus.Q = w_q;
`endif

  assign bus.BUSY     = (r_state != S_IDLE);
  assign bus.RDY      = (r_state == S_IDLE);
  assign bus.LD_READY = (r_state == S_LOAD);
  assign bus.ERR      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_prog_iram.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_iram
// Description : Self-checking bench for prog_iram (DATA_W=16, AW=8).
//               Fetch expectations go through a scoreboard queue; the
//               fetch latency follows IRAM_REGQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_iram;
  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 128;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  prog_iram_if #(.DATA_W(DW), .AW(AW)) ifc ();

  prog_iram #(.DATA_W(DW), .AW(AW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (ifc.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [15:0] sb_q[$];

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] q;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fetch(input logic [7:0] a, input logic [15:0] exp, input string nm);
    @(negedge CLK);
    ifc.ADDR = a;
    sb_q.push_back(exp);
`ifdef IRAM_REGQ_EN
    @(posedge CLK);
`endif
    #1;
    check(nm, {16'h0, ifc.Q}, {16'h0, sb_q.pop_front()});
  endtask

  // Counts edges from the current point until RDY rises; BUSY must hold.
  task automatic wait_rdy(output int n, output logic busy_ok);
    n = 0;
    busy_ok = 1'b1;
    do begin
      @(posedge CLK);
      #1;
      n++;
      if (!ifc.RDY && (ifc.BUSY !== 1'b1)) busy_ok = 1'b0;
    end while (!ifc.RDY && n < 400);
  endtask

  task automatic start_load();
    @(negedge CLK);
    ifc.LD_START = 1'b1;
    @(posedge CLK);
    #1;
    ifc.LD_START = 1'b0;
    check("start_ld_ready", {31'h0, ifc.LD_READY}, 32'd1);
    check("start_err_clr",  {31'h0, ifc.ERR},      32'd0);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int t;
    t = 0;
    @(negedge CLK);
    while (!ifc.LD_READY && t < 20) begin
      @(negedge CLK);
      t++;
    end
    if (!ifc.LD_READY) begin
      check("ld_ready_timeout", 32'd0, 32'd1);
      return;
    end
    ifc.LD_VALID = 1'b1;
    ifc.LD_DATA  = d;
    ifc.LD_LAST  = last;
    @(posedge CLK);
    #1;
    ifc.LD_VALID = 1'b0;
    ifc.LD_LAST  = 1'b0;
  endtask

  function automatic logic [7:0] ovf_byte(input int i);
    return 8'((i * 7 + 3) & 8'hFF);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic bok;

    tbl[0] = '{8'h00, 16'hF491};
    tbl[1] = '{8'h03, 16'hF1C9};
    tbl[2] = '{8'h01, 16'hF491};
    tbl[3] = '{8'h02, 16'hF1C9};
    tbl[4] = '{8'h04, 16'h0000};
    tbl[5] = '{8'h00, 16'h0001};
    tbl[6] = '{8'h02, 16'h00AB};
    tbl[7] = '{8'h05, 16'h0000};

    ifc.ADDR     = '0;
    ifc.LD_START = 1'b0;
    ifc.LD_VALID = 1'b0;
    ifc.LD_DATA  = '0;
    ifc.LD_LAST  = 1'b0;

    // Reset and clear sweep
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy",     {31'h0, ifc.BUSY},     32'd1);
    check("rst_rdy",      {31'h0, ifc.RDY},      32'd0);
    check("rst_ld_ready", {31'h0, ifc.LD_READY}, 32'd0);
    check("rst_err",      {31'h0, ifc.ERR},      32'd0);
    check("rst_q",        {16'h0, ifc.Q},        32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    wait_rdy(n, bok);
    check("clear_latency", n, 32'd128);
    check("clear_busy",    {31'h0, bok}, 32'd1);
    for (int a = 0; a < 256; a += 2) fetch(8'(a), 16'h0000, "clear_zero");

    // Four-byte load
    start_load();
    send_byte(8'h91, 1'b0);
    check("q_zero_in_load", {16'h0, ifc.Q}, 32'd0);
    send_byte(8'hF4, 1'b0);
    send_byte(8'hC9, 1'b0);
    send_byte(8'hF1, 1'b1);
    check("rdy_after_last",  {31'h0, ifc.RDY},      32'd1);
    check("ldrdy_after_last",{31'h0, ifc.LD_READY}, 32'd0);
    for (int i = 0; i < 5; i++) fetch(tbl[i].addr, tbl[i].q, "tbl_load4");

    // Short final word padded with zero
    start_load();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hAB, 1'b1);
    check("short_err", {31'h0, ifc.ERR}, 32'd0);
    for (int i = 5; i < 8; i++) fetch(tbl[i].addr, tbl[i].q, "tbl_load3");

    // Overflow: 256 bytes with no LD_LAST
    start_load();
    for (int i = 0; i < 256; i++) send_byte(ovf_byte(i), 1'b0);
    check("ovf_ld_ready", {31'h0, ifc.LD_READY}, 32'd0);
    check("ovf_err",      {31'h0, ifc.ERR},      32'd1);
    check("ovf_rdy",      {31'h0, ifc.RDY},      32'd1);
    @(negedge CLK);
    ifc.LD_VALID = 1'b1;
    ifc.LD_DATA  = 8'hEE;
    ifc.LD_LAST  = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    ifc.LD_VALID = 1'b0;
    ifc.LD_LAST  = 1'b0;
    check("ovf_err_sticky", {31'h0, ifc.ERR}, 32'd1);
    fetch(8'hFE, {ovf_byte(255), ovf_byte(254)}, "ovf_word127");
    fetch(8'h00, {ovf_byte(1),   ovf_byte(0)},   "ovf_word0");
    fetch(8'h80, {ovf_byte(129), ovf_byte(128)}, "ovf_word64");
    start_load();
    send_byte(8'h77, 1'b1);
    fetch(8'h00, 16'h0077, "reload_word0");
    fetch(8'h02, {ovf_byte(3), ovf_byte(2)}, "reload_word1");

    // Reset in the middle of a load
    start_load();
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    check("midrst_busy",     {31'h0, ifc.BUSY},     32'd1);
    check("midrst_rdy",      {31'h0, ifc.RDY},      32'd0);
    check("midrst_ld_ready", {31'h0, ifc.LD_READY}, 32'd0);
    check("midrst_q",        {16'h0, ifc.Q},        32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    wait_rdy(n, bok);
    check("midrst_latency", n, 32'd128);
    check("midrst_err",     {31'h0, ifc.ERR}, 32'd0);
    for (int a = 0; a < 256; a += 2) fetch(8'(a), 16'h0000, "midrst_zero");

    // Fetch latency on an address change
    start_load();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    fetch(8'h00, 16'h2211, "lat_word0");
    @(negedge CLK);
    ifc.ADDR = 8'h02;
    #1;
`ifdef IRAM_REGQ_EN
    check("lat_same_cycle", {16'h0, ifc.Q}, 32'h2211);
`else
    check("lat_same_cycle", {16'h0, ifc.Q}, 32'h4433);
`endif
    @(posedge CLK);
    #1;
    check("lat_next_edge", {16'h0, ifc.Q}, 32'h4433);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
